ch0_sched: RTL and testbench
============================

# ch0_sched

Scheduler and sequencer for one DMA channel's source/destination FIFO pair. It accepts a descriptor with source address, destination address and byte count. It then time-shares the single Wishbone burst engine between source reads (stream 0, filling the source FIFO) and destination writes (stream 1, draining the destination FIFO). It also drives the channel's clear, last and end-of-job sideband, and reports completion.

## Interface
- BURST, 16: maximum burst length in 64-bit words; must be a power of two, ≤ 2^LENW − 1.
- LENW, 5: width of eng_len.
- wb_clk_i  in  1  single clock; all logic rises on it.
- wb_rst_n  in  1  asynchronous, active-low reset.
- desc_valid  in  1  descriptor offered.
- desc_ready  out  1  high only in IDLE; accept = desc_valid && desc_ready.
- desc_src  in  32  source byte address; bits [2:0] are ignored and treated as 0.
- desc_dst  in  32  destination byte address; bits [2:0] are ignored and treated as 0.
- desc_dc  in  24  byte count.
- abort_i  in  1  abort the job.
- eng_start  out  1  one-cycle burst request.
- eng_dir  out  1  0 = read into stream 0, 1 = write from stream 1.
- eng_adr  out  32  burst start address, 8-byte aligned.
- eng_len  out  LENW  burst length in words, 1..BURST.
- eng_done  in  1  one-cycle pulse when the engine has finished or stopped the current burst.
- ss_xfer0 / ss_xfer1  in  1  word accepted into the source FIFO / taken from the destination FIFO.
- ss_start0 / ss_start1  in  1  source FIFO has room for a burst / destination FIFO has a burst available.
- ss_last0  out  1  marks the final source word.
- m_reset0  out  1  FIFO clear pulse.
- m_endn0  out  1  active-low: all source words have been read.
- done_o  out  1  one-cycle pulse when the job completes or the abort finishes.
- busy_o  out  1  high whenever the state is not IDLE.

## Operation
- Word count: words = desc_dc[23:3] + (|desc_dc[2:0]). This is 22 bits wide, so partial bytes round up.
- Registers captured on accept:
  - rd_left = words, wr_left = words (22 bits each).
  - rd_adr = {desc_src[31:3],3'b0}, wr_adr = {desc_dst[31:3],3'b0}.
  - rd_xcnt = words; it decrements on ss_xfer0.
- States: IDLE, CLR, ARB, RD, WR, ABRT, FIN.
- IDLE: on accept, go to CLR.
- CLR: m_reset0 = 1 for exactly one cycle.
  - If words == 0, go to FIN.
  - Otherwise go to ARB.
- ARB: eligibility.
  - Read is eligible when rd_left ≠ 0 and ss_start0.
  - Write is eligible when wr_left ≠ 0 and ss_start1.
  - If both are eligible, the direction opposite to last_dir wins; last_dir resets to 1, so the first tie goes to read.
  - The granted direction issues eng_start in the same cycle as the ARB decision and moves to RD or WR.
  - If neither is eligible, stay in ARB.
- Burst length: len = min(BURST, remaining). eng_adr, eng_len and eng_dir are registered and held stable from eng_start until eng_done.
- RD and WR: wait for eng_done.
  - Words actually moved = count of ss_xfer0 (RD) or ss_xfer1 (WR) during the burst. This count is ≤ len, because the engine may stop early on FIFO stop.
  - On eng_done: remaining −= moved; address += moved×8 (32-bit wrap allowed); last_dir = dir.
  - If wr_left reaches 0, go to FIN; otherwise return to ARB.
- ss_last0 = ss_xfer0 && (rd_xcnt == 1). This is combinational and asserts for exactly one word per job.
- m_endn0 = 0 from the cycle after rd_xcnt reaches 0 until FIN. It is 1 otherwise.
- FIN: done_o = 1 for one cycle, then go to IDLE.
- abort_i:
  - In CLR or ARB: go to ABRT immediately.
  - In RD or WR: latch the abort; after eng_done, go to ABRT.
  - ABRT: m_reset0 = 1 for one cycle, then go to FIN.
- ss_xfer0 outside RD and ss_xfer1 outside WR are ignored and do not change counters.
- The counters must never underflow: moved > remaining saturates remaining at 0.

## Timing
- Reset values:
  - state = IDLE; desc_ready = 1; busy_o = 0.
  - eng_start = 0, eng_dir = 0, eng_adr = 0, eng_len = 0.
  - m_reset0 = 0, m_endn0 = 1, ss_last0 = 0, done_o = 0.
  - All counters = 0; last_dir = 1.
- Accept at edge N:
  - m_reset0 is high in cycle N+1.
  - The earliest eng_start is in cycle N+2.
- eng_start is high for exactly one cycle and is never reissued before eng_done.
  - An eng_done arriving in the same cycle as eng_start is ignored; the engine cannot complete in zero cycles.
- eng_done at edge M:
  - Remaining count and address are updated at M.
  - ARB is re-entered at M, so the next eng_start is no earlier than M+1.
- done_o fires one cycle after the final eng_done.
- Asserting wb_rst_n low mid-job forces all outputs to their reset values asynchronously. There is no done_o pulse.

## Test plan
- desc_dc = 64, BURST = 16, ss_start0 = ss_start1 = 1, engine moves full len:
  - eng_start sequence: RD len 8 at adr src, then WR len 8 at adr dst.
  - ss_last0 on the 8th ss_xfer0.
  - done_o fires once.
- desc_dc = 300 (38 words), both starts high:
  - Bursts alternate RD 16, WR 16, RD 16, WR 16, RD 6, WR 6.
  - Addresses advance by 128 per full burst.
- desc_dc = 5: words = 1; one RD len 1 and one WR len 1; ss_last0 coincides with the single xfer.
- desc_dc = 0: m_reset0 pulse, then done_o two cycles after accept; no eng_start.
- Engine stops early: RD len 16 but only 10 ss_xfer0 before eng_done.
  - rd_left drops by 10; the next RD adr = src + 80.
  - m_endn0 deasserts only after all words are read.
- abort_i during WR: no new eng_start after eng_done; a one-cycle m_reset0, then done_o.
- wb_rst_n pulsed low mid-RD: outputs return to their reset values immediately and desc_ready = 1 after release.

Source files
------------

// File: rtl/ch0_sched.sv
// Scheduler/sequencer for one DMA channel: shares the burst engine between
// source reads (stream 0) and destination writes (stream 1) and drives FIFO sideband.
//
// state | meaning
// IDLE  | waiting for a descriptor
// CLR   | one-cycle FIFO clear after accept
// ARB   | choose next burst direction, issue eng_start
// RD    | read burst in flight (stream 0)
// WR    | write burst in flight (stream 1)
// ABRT  | one-cycle FIFO clear after an abort
// FIN   | one-cycle done pulse
module ch0_sched #(
  parameter int BURST = 16,
  parameter int LENW  = 5
) (
  input  logic            wb_clk_i,
  input  logic            wb_rst_n,
  input  logic            desc_valid,
  output logic            desc_ready,
  input  logic [31:0]     desc_src,
  input  logic [31:0]     desc_dst,
  input  logic [23:0]     desc_dc,
  input  logic            abort_i,
  output logic            eng_start,
  output logic            eng_dir,
  output logic [31:0]     eng_adr,
  output logic [LENW-1:0] eng_len,
  input  logic            eng_done,
  input  logic            ss_xfer0,
  input  logic            ss_xfer1,
  input  logic            ss_start0,
  input  logic            ss_start1,
  output logic            ss_last0,
  output logic            m_reset0,
  output logic            m_endn0,
  output logic            done_o,
  output logic            busy_o
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_CLR  = 3'd1;
  localparam logic [2:0] S_ARB  = 3'd2;
  localparam logic [2:0] S_RD   = 3'd3;
  localparam logic [2:0] S_WR   = 3'd4;
  localparam logic [2:0] S_ABRT = 3'd5;
  localparam logic [2:0] S_FIN  = 3'd6;

  localparam logic [21:0]     BURST_W = 22'(BURST);
  localparam logic [LENW-1:0] BURST_L = LENW'(BURST);

  logic [2:0]      state;
  logic [21:0]     rd_left, wr_left, rd_xcnt, moved;
  logic [31:0]     rd_adr, wr_adr;
  logic            last_dir, abort_q, rd_end;
  logic            dir_q;
  logic [31:0]     adr_q;
  logic [LENW-1:0] len_q;

  logic [21:0]     words, arb_rem, moved_tot, cur_left, new_left;
  logic [31:0]     arb_adr, new_adr;
  logic [LENW-1:0] arb_len;
  logic            accept, in_arb, rd_elig, wr_elig, grant_rd, grant_wr;
  logic            xfer_now, wr_zero_next;
  logic            unused_lsbs;

  assign unused_lsbs = ^{desc_src[2:0], desc_dst[2:0]};

  assign words  = {1'b0, desc_dc[23:3]} + {21'd0, |desc_dc[2:0]};
  assign accept = desc_valid && (state == S_IDLE);
  assign in_arb = (state == S_ARB);

  // On a tie the direction not used last time wins.
  assign rd_elig  = (rd_left != 22'd0) && ss_start0;
  assign wr_elig  = (wr_left != 22'd0) && ss_start1;
  assign grant_rd = rd_elig && (!wr_elig || last_dir);
  assign grant_wr = wr_elig && (!rd_elig || !last_dir);

  assign arb_adr = grant_wr ? wr_adr  : rd_adr;
  assign arb_rem = grant_wr ? wr_left : rd_left;
  assign arb_len = (arb_rem >= BURST_W) ? BURST_L : arb_rem[LENW-1:0];

  // Burst request is decided and issued in the same ARB cycle, then held in registers.
  assign eng_start = in_arb && !abort_i && (grant_rd || grant_wr);
  assign eng_dir   = in_arb ? grant_wr : dir_q;
  assign eng_adr   = in_arb ? arb_adr  : adr_q;
  assign eng_len   = in_arb ? arb_len  : len_q;

  assign xfer_now  = ((state == S_RD) && ss_xfer0) || ((state == S_WR) && ss_xfer1);
  assign moved_tot = moved + {21'd0, xfer_now};
  assign cur_left  = dir_q ? wr_left : rd_left;
  assign new_left  = (moved_tot >= cur_left) ? 22'd0 : (cur_left - moved_tot);
  assign new_adr   = (dir_q ? wr_adr : rd_adr) + {7'd0, moved_tot, 3'b000};
  assign wr_zero_next = dir_q ? (new_left == 22'd0) : (wr_left == 22'd0);

  assign ss_last0   = (state == S_RD) && ss_xfer0 && (rd_xcnt == 22'd1);
  assign m_endn0    = !(rd_end && (state != S_IDLE) && (state != S_FIN));
  assign m_reset0   = (state == S_CLR) || (state == S_ABRT);
  assign done_o     = (state == S_FIN);
  assign busy_o     = (state != S_IDLE);
  assign desc_ready = (state == S_IDLE);

  always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      state    <= S_IDLE;
      rd_left  <= '0;
      wr_left  <= '0;
      rd_xcnt  <= '0;
      moved    <= '0;
      rd_adr   <= '0;
      wr_adr   <= '0;
      last_dir <= 1'b1;
      abort_q  <= 1'b0;
      rd_end   <= 1'b0;
      dir_q    <= 1'b0;
      adr_q    <= '0;
      len_q    <= '0;
    end else begin
      if ((state == S_RD) || (state == S_WR)) begin
        if (eng_done)      moved <= '0;
        else if (xfer_now) moved <= moved_tot;
      end else begin
        moved <= '0;
      end

      case (state)
        S_IDLE: begin
          if (accept) begin
            rd_left <= words;
            wr_left <= words;
            rd_xcnt <= words;
            rd_adr  <= {desc_src[31:3], 3'b000};
            wr_adr  <= {desc_dst[31:3], 3'b000};
            abort_q <= 1'b0;
            rd_end  <= 1'b0;
            state   <= S_CLR;
          end
        end
        S_CLR: begin
          if (abort_i)                  state <= S_ABRT;
          else if (wr_left == 22'd0)    state <= S_FIN;
          else                          state <= S_ARB;
        end
        S_ARB: begin
          if (abort_i) begin
            state <= S_ABRT;
          end else if (grant_rd || grant_wr) begin
            dir_q <= grant_wr;
            adr_q <= arb_adr;
            len_q <= arb_len;
            state <= grant_wr ? S_WR : S_RD;
          end
        end
        S_RD, S_WR: begin
          if (abort_i) abort_q <= 1'b1;
          if ((state == S_RD) && ss_xfer0 && (rd_xcnt != 22'd0)) begin
            rd_xcnt <= rd_xcnt - 22'd1;
            if (rd_xcnt == 22'd1) rd_end <= 1'b1;
          end
          if (eng_done) begin
            if (dir_q) begin
              wr_left <= new_left;
              wr_adr  <= new_adr;
            end else begin
              rd_left <= new_left;
              rd_adr  <= new_adr;
            end
            last_dir <= dir_q;
            if (abort_q || abort_i) state <= S_ABRT;
            else if (wr_zero_next)  state <= S_FIN;
            else                    state <= S_ARB;
          end
        end
        S_ABRT: begin
          abort_q <= 1'b0;
          state   <= S_FIN;
        end
        S_FIN:   state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ch0_sched.sv
// Directed bench for ch0_sched: a job table with hand-computed burst sequences,
// a simple engine responder, plus reset-state and mid-job reset sequences.
module tb_ch0_sched;

  logic        wb_clk_i = 1'b0;
  logic        wb_rst_n = 1'b0;
  logic        desc_valid = 1'b0;
  logic        desc_ready;
  logic [31:0] desc_src = '0;
  logic [31:0] desc_dst = '0;
  logic [23:0] desc_dc = '0;
  logic        abort_i = 1'b0;
  logic        eng_start, eng_dir;
  logic [31:0] eng_adr;
  logic [4:0]  eng_len;
  logic        eng_done = 1'b0;
  logic        ss_xfer0 = 1'b0;
  logic        ss_xfer1 = 1'b0;
  logic        ss_start0 = 1'b1;
  logic        ss_start1 = 1'b1;
  logic        ss_last0, m_reset0, m_endn0, done_o, busy_o;

  always #5 wb_clk_i = ~wb_clk_i;

  ch0_sched #(.BURST(16), .LENW(5)) dut (
    .wb_clk_i(wb_clk_i), .wb_rst_n(wb_rst_n),
    .desc_valid(desc_valid), .desc_ready(desc_ready),
    .desc_src(desc_src), .desc_dst(desc_dst), .desc_dc(desc_dc),
    .abort_i(abort_i),
    .eng_start(eng_start), .eng_dir(eng_dir), .eng_adr(eng_adr), .eng_len(eng_len),
    .eng_done(eng_done),
    .ss_xfer0(ss_xfer0), .ss_xfer1(ss_xfer1),
    .ss_start0(ss_start0), .ss_start1(ss_start1),
    .ss_last0(ss_last0), .m_reset0(m_reset0), .m_endn0(m_endn0),
    .done_o(done_o), .busy_o(busy_o)
  );

  typedef struct {
    logic        dir;
    logic [31:0] adr;
    logic [4:0]  len;
  } burst_t;

  typedef struct {
    logic [31:0] src;
    logic [31:0] dst;
    logic [23:0] dc;
    int          words;
    int          b0;
    int          nb;
    int          stop_burst;
    int          stop_moved;
    int          abort_burst;
  } job_t;

  burst_t eb[16];
  job_t   jobs[6];
  int     n_cmp = 0;
  int     n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge wb_clk_i);
    #1;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_desc_ready"}, desc_ready, 1);
    chk({tag, "_busy"}, busy_o, 0);
    chk({tag, "_eng_start"}, eng_start, 0);
    chk({tag, "_eng_dir"}, eng_dir, 0);
    chk({tag, "_eng_adr"}, eng_adr, 0);
    chk({tag, "_eng_len"}, eng_len, 0);
    chk({tag, "_m_reset0"}, m_reset0, 0);
    chk({tag, "_m_endn0"}, m_endn0, 1);
    chk({tag, "_ss_last0"}, ss_last0, 0);
    chk({tag, "_done"}, done_o, 0);
  endtask

  task automatic run_job(input int j);
    job_t   jb;
    burst_t e;
    int     bi, cyc, rd_words, last_cnt, done_cnt, rst_cnt, mv;
    logic   d, exp_last;
    jb = jobs[j];
    bi = 0; cyc = 0; rd_words = 0; last_cnt = 0; done_cnt = 0;
    chk($sformatf("j%0d_ready", j), desc_ready, 1);
    desc_src = jb.src; desc_dst = jb.dst; desc_dc = jb.dc; desc_valid = 1'b1;
    tick();
    desc_valid = 1'b0;
    chk($sformatf("j%0d_mreset_n1", j), m_reset0, 1);
    chk($sformatf("j%0d_busy", j), busy_o, 1);
    rst_cnt = 1;
    tick();
    if (jb.nb == 0) begin
      chk($sformatf("j%0d_done_n2", j), done_o, 1);
      chk($sformatf("j%0d_nostart", j), eng_start, 0);
    end else begin
      chk($sformatf("j%0d_start_n2", j), eng_start, 1);
    end
    while (cyc < 2000) begin
      if (done_o) begin
        done_cnt++;
        break;
      end
      if (m_reset0) rst_cnt++;
      if (eng_start) begin
        chk($sformatf("j%0d_start_in_range", j), (bi < jb.nb) ? 1 : 0, 1);
        if (bi < jb.nb) begin
          e = eb[jb.b0 + bi];
          chk($sformatf("j%0d_b%0d_dir", j, bi), eng_dir, e.dir);
          chk($sformatf("j%0d_b%0d_adr", j, bi), eng_adr, e.adr);
          chk($sformatf("j%0d_b%0d_len", j, bi), eng_len, e.len);
        end
        d  = eng_dir;
        mv = (bi == jb.stop_burst) ? jb.stop_moved : int'(eng_len);
        tick();
        for (int k = 0; k < mv; k++) begin
          if (!d) begin
            ss_xfer0 = 1'b1;
            rd_words++;
          end else begin
            ss_xfer1 = 1'b1;
          end
          if (bi == jb.abort_burst && k == 0) abort_i = 1'b1;
          #1;
          if (!d) begin
            exp_last = (rd_words == jb.words);
            if (ss_last0) last_cnt++;
            if (exp_last) chk($sformatf("j%0d_last0", j), ss_last0, 1);
          end
          chk($sformatf("j%0d_no_restart", j), eng_start, 0);
          @(posedge wb_clk_i);
          #1;
          ss_xfer0 = 1'b0; ss_xfer1 = 1'b0; abort_i = 1'b0;
        end
        eng_done = 1'b1;
        tick();
        eng_done = 1'b0;
        if (bi == jb.abort_burst) begin
          chk($sformatf("j%0d_abrt_reset", j), m_reset0, 1);
          chk($sformatf("j%0d_abrt_nostart", j), eng_start, 0);
        end else begin
          if (!d) chk($sformatf("j%0d_endn0_b%0d", j, bi), m_endn0, (rd_words < jb.words) ? 1 : 0);
          if (bi + 1 == jb.nb) chk($sformatf("j%0d_done_after_last", j), done_o, 1);
        end
        bi++;
        cyc++;
      end else begin
        tick();
        cyc++;
      end
    end
    chk($sformatf("j%0d_timeout", j), (cyc < 2000) ? 1 : 0, 1);
    chk($sformatf("j%0d_bursts", j), bi, jb.nb);
    chk($sformatf("j%0d_done_cnt", j), done_cnt, 1);
    chk($sformatf("j%0d_last_cnt", j), last_cnt,
        (jb.abort_burst < 0 && jb.words > 0) ? 1 : 0);
    chk($sformatf("j%0d_mreset_cnt", j), rst_cnt, (jb.abort_burst >= 0) ? 2 : 1);
    tick();
    chk($sformatf("j%0d_done_once", j), done_o, 0);
    chk($sformatf("j%0d_idle", j), desc_ready, 1);
    chk($sformatf("j%0d_endn_idle", j), m_endn0, 1);
  endtask

  initial begin
    int cyc;
    eb[0]  = '{1'b0, 32'h0000_1000, 5'd8};
    eb[1]  = '{1'b1, 32'h0000_2000, 5'd8};
    eb[2]  = '{1'b0, 32'h0001_0000, 5'd16};
    eb[3]  = '{1'b1, 32'h2000_0000, 5'd16};
    eb[4]  = '{1'b0, 32'h0001_0080, 5'd16};
    eb[5]  = '{1'b1, 32'h2000_0080, 5'd16};
    eb[6]  = '{1'b0, 32'h0001_0100, 5'd6};
    eb[7]  = '{1'b1, 32'h2000_0100, 5'd6};
    eb[8]  = '{1'b0, 32'h0000_3008, 5'd1};
    eb[9]  = '{1'b1, 32'h0000_4010, 5'd1};
    eb[10] = '{1'b0, 32'h0000_5000, 5'd16};
    eb[11] = '{1'b1, 32'h0000_6000, 5'd16};
    eb[12] = '{1'b0, 32'h0000_5050, 5'd10};
    eb[13] = '{1'b1, 32'h0000_6080, 5'd4};
    eb[14] = '{1'b0, 32'h0000_7000, 5'd16};
    eb[15] = '{1'b1, 32'h0000_8000, 5'd16};

    //           src            dst            dc      words b0  nb stop moved abort
    jobs[0] = '{32'h0000_1000, 32'h0000_2000, 24'd64,  8,  0,  2, -1, 0,  -1};
    jobs[1] = '{32'h0001_0003, 32'h2000_0007, 24'd300, 38, 2,  6, -1, 0,  -1};
    jobs[2] = '{32'h0000_300B, 32'h0000_4010, 24'd5,   1,  8,  2, -1, 0,  -1};
    jobs[3] = '{32'h0000_9000, 32'h0000_A000, 24'd0,   0,  10, 0, -1, 0,  -1};
    jobs[4] = '{32'h0000_5000, 32'h0000_6000, 24'd160, 20, 10, 4, 0,  10, -1};
    jobs[5] = '{32'h0000_7000, 32'h0000_8000, 24'd256, 32, 14, 2, -1, 0,  1};

    #3;
    chk_reset_outputs("por");
    #9 wb_rst_n = 1'b1;
    tick();
    chk_reset_outputs("post_rel");

    for (int j = 0; j < 6; j++) run_job(j);

    // Reset pulsed low in the middle of a read burst.
    desc_src = 32'h0001_0000; desc_dst = 32'h2000_0000; desc_dc = 24'd300; desc_valid = 1'b1;
    tick();
    desc_valid = 1'b0;
    cyc = 0;
    while (!eng_start && cyc < 20) begin
      tick();
      cyc++;
    end
    chk("mid_rst_start_seen", eng_start, 1);
    tick();
    ss_xfer0 = 1'b1;
    tick();
    tick();
    #2 wb_rst_n = 1'b0;
    #1;
    chk_reset_outputs("mid_rst");
    ss_xfer0 = 1'b0;
    #3 wb_rst_n = 1'b1;
    tick();
    chk_reset_outputs("mid_rst_rel");

    run_job(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
